lsu_wb: RTL and testbench
=========================

# lsu_wb

Load/store unit with writeback formatting, sitting between the execute stage and the register file. Accepts one memory operation at a time and drives a valid/ready memory port with 8-byte-aligned addresses and byte-lane masks. Shifts and sign- or zero-extends load data, then issues the register-file write port (`reg_wen`/`reg_waddr`/`reg_wdata`) for exactly one cycle. Stores complete without a register write.

## Interface
- `XLEN`, 64, data/address width; fixed at 64 (RV64), other values unsupported.
- `RA_W`, 5, register address width.
- `clk`  in  1  clock; all state changes on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `req_valid`  in  1  execute stage presents an operation.
- `req_ready`  out  1  high only in IDLE; accept = `req_valid && req_ready`.
- `req_op`  in  4  bit3 = store; [2:0] = funct3. Loads: LB 000, LH 001, LW 010, LD 011, LBU 100, LHU 101, LWU 110. Stores: SB 000, SH 001, SW 010, SD 011.
- `req_addr`  in  XLEN  effective byte address (rs1 + imm).
- `req_wdata`  in  XLEN  store data (rs2).
- `req_rd`  in  RA_W  load destination register.
- `mem_req_valid`  out  1  memory request valid.
- `mem_req_ready`  in  1  memory accepts the request.
- `mem_addr`  out  XLEN  `{addr[63:3], 3'b0}`.
- `mem_wen`  out  1  1 = write.
- `mem_wdata`  out  XLEN  store data shifted left by `addr[2:0]*8`.
- `mem_wmask`  out  8  byte enables: 1/3/F/FF shifted left by `addr[2:0]`; 0 for loads.
- `mem_rsp_valid`  in  1  read data valid / write acknowledge.
- `mem_rdata`  in  XLEN  aligned 8-byte read data.
- `reg_wen`  out  1  register-file write enable; one-cycle pulse.
- `reg_waddr`  out  RA_W  register-file write address.
- `reg_wdata`  out  XLEN  formatted load result.
- `misalign`  out  1  one-cycle pulse on a misaligned request.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- States: IDLE, REQ, WAIT, WB.
- **Accept.** On accept in IDLE, latch op, addr, wdata and rd.
- **Alignment check.** Size is 1/2/4/8 bytes from `op[1:0]`. If `addr` is not a multiple of the size:
  - pulse `misalign` the next cycle;
  - stay in IDLE; no memory access, no register write.
- **Aligned request.** IDLE → REQ.
- **REQ.** Hold `mem_req_valid` and all `mem_*` request fields stable until `mem_req_ready`, then go to WAIT.
- **WAIT.**
  - `mem_rsp_valid` is ignored in IDLE and REQ.
  - Load response: capture `mem_rdata >> (addr[2:0]*8)`, extend per funct3 (bit2 = unsigned), go to WB.
  - Store acknowledge: go to IDLE.
- **WB.** Drive `reg_wen`=1 for one cycle when `rd != 0`, with `reg_waddr`=rd and `reg_wdata`=formatted value. If `rd == 0`, `reg_wen` stays 0. Then go to IDLE.
- **Output values.**
  - `reg_wdata` and `reg_waddr` hold their last values outside WB.
  - `mem_wen`, `mem_wmask` and `mem_wdata` are 0 whenever `mem_req_valid`=0.
- **Illegal encodings.** Load funct3 111 and store funct3 1xx are treated as LD/SD-size no-ops: `misalign` stays 0, no access is made, return to IDLE.

## Timing
- **Reset values.** State IDLE; `req_ready`=1; `mem_req_valid`=0; `mem_wen`=0; `mem_wmask`=0; `mem_addr`=0; `mem_wdata`=0; `reg_wen`=0; `reg_waddr`=0; `reg_wdata`=0; `misalign`=0; `busy`=0.
- **Reset mid-operation.** `rst` in any state forces the reset values on the next edge and abandons the operation. A later `mem_rsp_valid` for the abandoned operation is ignored.
- **Load latency, zero-wait memory.**
  - Accept at cycle 0.
  - `mem_req_valid` high at cycle 1; with `mem_req_ready` it is accepted at cycle 1.
  - Earliest `mem_rsp_valid` at cycle 2.
  - `reg_wen` high at cycle 3.
  - `req_ready` high at cycle 4.
- **Store latency.** Acknowledge at cycle 2 puts `req_ready` high at cycle 3.
- **Throughput.** One operation outstanding at a time; the next request is accepted only in IDLE.
- **Same-cycle response.** `mem_rsp_valid` arriving in the same cycle as `mem_req_ready` is not sampled; the response counts only in WAIT.

## Test plan
- **LW sign-extend.** LW, addr 0x8000_0004, rd 10, `mem_rdata` 0x8765_4321_0000_0000 → `mem_addr` 0x8000_0000, `mem_wmask` 0; `reg_wen` at cycle 3, `reg_waddr` 10, `reg_wdata` 0xFFFF_FFFF_8765_4321.
- **Byte loads.** LB/LBU at 0x8000_0007, `mem_rdata` 0xAB00_0000_0000_0000 → LB gives 0xFFFF_FFFF_FFFF_FFAB; LBU gives 0x0000_0000_0000_00AB.
- **SH lane placement.** SH addr 0x8000_0002, data 0x1234 → `mem_wen` 1, `mem_wmask` 0x0C, `mem_wdata` 0x0000_0000_1234_0000; after ack, `reg_wen` never asserts.
- **Misaligned LD.** LD at 0x8000_0004 → `misalign` pulse at cycle 1, `mem_req_valid` stays 0, `req_ready` stays 1.
- **Backpressure.** `mem_req_ready` low for 3 cycles → `mem_addr`, `mem_wmask` and `mem_wdata` stable throughout. Then response delayed 5 cycles → `busy`=1 until WB completes.
- **rd=0 and reset.**
  - LD to rd 0 → memory access occurs, `reg_wen` stays 0.
  - `rst` asserted in WAIT → reset values next cycle; a subsequent `mem_rsp_valid` produces no `reg_wen`.

Source files
------------

// File: rtl/lsu_wb.sv
// Load/store unit with writeback formatting.
// Handles one memory operation at a time. Loads are shifted and extended
// into a one-cycle register-file write. Stores finish on the memory
// acknowledge and never write the register file.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high. Once valid is raised, it and its payload stay stable until that
// edge. req_ready is high only in IDLE. mem_req_valid is held with stable
// mem_addr, mem_wen, mem_wmask and mem_wdata until mem_req_ready is seen.
// mem_rsp_valid is sampled only in WAIT.
module lsu_wb #(
   parameter int XLEN = 64,
   parameter int RA_W = 5
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic [3:0]      req_op,
   input  logic [XLEN-1:0] req_addr,
   input  logic [XLEN-1:0] req_wdata,
   input  logic [RA_W-1:0] req_rd,
   output logic            mem_req_valid,
   input  logic            mem_req_ready,
   output logic [XLEN-1:0] mem_addr,
   output logic            mem_wen,
   output logic [XLEN-1:0] mem_wdata,
   output logic [7:0]      mem_wmask,
   input  logic            mem_rsp_valid,
   input  logic [XLEN-1:0] mem_rdata,
   output logic            reg_wen,
   output logic [RA_W-1:0] reg_waddr,
   output logic [XLEN-1:0] reg_wdata,
   output logic            misalign,
   output logic            busy,
   output logic [1:0]      dbg_state
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      WB   = 2'd3
   } state_t;

   state_t          state;
   logic [2:0]      funct3_q;
   logic [2:0]      off_q;
   logic            store_q;
   logic [RA_W-1:0] rd_q;

   logic [2:0]      req_off;
   logic [5:0]      req_sh;
   logic            req_store;
   logic            req_illegal;
   logic            req_misal;
   logic [7:0]      req_mask;
   logic [XLEN-1:0] ld_shift;
   logic [XLEN-1:0] ld_fmt;

   assign req_off     = req_addr[2:0];
   assign req_sh      = {req_off, 3'b000};
   assign req_store   = req_op[3];
   // Load funct3 111 and store funct3 1xx have no defined access size.
   assign req_illegal = req_store ? req_op[2] : (req_op[2:0] == 3'b111);

   assign req_ready = (state == IDLE);
   assign busy      = (state != IDLE);
   assign dbg_state = state;

   // Access size from op[1:0]: alignment test and unshifted byte-lane mask.
   always_comb begin
      req_misal = 1'b0;
      req_mask  = 8'h00;
      case (req_op[1:0])
         2'b00: begin
            req_misal = 1'b0;
            req_mask  = 8'h01;
         end
         2'b01: begin
            req_misal = req_off[0];
            req_mask  = 8'h03;
         end
         2'b10: begin
            req_misal = |req_off[1:0];
            req_mask  = 8'h0F;
         end
         default: begin
            req_misal = |req_off;
            req_mask  = 8'hFF;
         end
      endcase
   end

   assign ld_shift = mem_rdata >> {off_q, 3'b000};

   // Extend the shifted load data. funct3 bit2 selects zero extension.
   always_comb begin
      ld_fmt = ld_shift;
      case (funct3_q)
         3'b000:  ld_fmt = {{(XLEN-8){ld_shift[7]}},   ld_shift[7:0]};
         3'b001:  ld_fmt = {{(XLEN-16){ld_shift[15]}}, ld_shift[15:0]};
         3'b010:  ld_fmt = {{(XLEN-32){ld_shift[31]}}, ld_shift[31:0]};
         3'b100:  ld_fmt = {{(XLEN-8){1'b0}},          ld_shift[7:0]};
         3'b101:  ld_fmt = {{(XLEN-16){1'b0}},         ld_shift[15:0]};
         3'b110:  ld_fmt = {{(XLEN-32){1'b0}},         ld_shift[31:0]};
         default: ld_fmt = ld_shift;
      endcase
   end

   // Operation sequencer. All outputs except req_ready and busy are registered.
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         funct3_q      <= 3'b000;
         off_q         <= 3'b000;
         store_q       <= 1'b0;
         rd_q          <= '0;
         mem_req_valid <= 1'b0;
         mem_addr      <= '0;
         mem_wen       <= 1'b0;
         mem_wdata     <= '0;
         mem_wmask     <= 8'h00;
         reg_wen       <= 1'b0;
         reg_waddr     <= '0;
         reg_wdata     <= '0;
         misalign      <= 1'b0;
      end else begin
         misalign <= 1'b0;
         reg_wen  <= 1'b0;
         case (state)
            IDLE: begin
               if (req_valid) begin
                  funct3_q <= req_op[2:0];
                  off_q    <= req_off;
                  store_q  <= req_store;
                  rd_q     <= req_rd;
                  if (req_illegal) begin
                     state <= IDLE;
                  end else if (req_misal) begin
                     misalign <= 1'b1;
                     state    <= IDLE;
                  end else begin
                     state         <= REQ;
                     mem_req_valid <= 1'b1;
                     mem_addr      <= {req_addr[XLEN-1:3], 3'b000};
                     mem_wen       <= req_store;
                     mem_wmask     <= req_store ? (req_mask << req_off) : 8'h00;
                     mem_wdata     <= req_store ? (req_wdata << req_sh) : '0;
                  end
               end
            end
            REQ: begin
               if (mem_req_ready) begin
                  state         <= WAIT;
                  mem_req_valid <= 1'b0;
                  mem_wen       <= 1'b0;
                  mem_wmask     <= 8'h00;
                  mem_wdata     <= '0;
               end
            end
            WAIT: begin
               if (mem_rsp_valid) begin
                  if (store_q) begin
                     state <= IDLE;
                  end else begin
                     state <= WB;
                     if (rd_q != '0) begin
                        reg_wen   <= 1'b1;
                        reg_waddr <= rd_q;
                        reg_wdata <= ld_fmt;
                     end
                  end
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lsu_wb.sv
// Bench for lsu_wb: directed test-plan cases with literal expectations,
// then randomized operations checked every cycle against a transaction model.
module tb_lsu_wb;
   localparam int XLEN = 64;
   localparam int RA_W = 5;
   localparam int W    = RA_W + XLEN;

   logic            clk = 1'b0;
   logic            rst;
   logic            req_valid;
   logic            req_ready;
   logic [3:0]      req_op;
   logic [XLEN-1:0] req_addr;
   logic [XLEN-1:0] req_wdata;
   logic [RA_W-1:0] req_rd;
   logic            mem_req_valid;
   logic            mem_req_ready;
   logic [XLEN-1:0] mem_addr;
   logic            mem_wen;
   logic [XLEN-1:0] mem_wdata;
   logic [7:0]      mem_wmask;
   logic            mem_rsp_valid;
   logic [XLEN-1:0] mem_rdata;
   logic            reg_wen;
   logic [RA_W-1:0] reg_waddr;
   logic [XLEN-1:0] reg_wdata;
   logic            misalign;
   logic            busy;
   logic [1:0]      dbg_state;

   lsu_wb #(.XLEN(XLEN), .RA_W(RA_W)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
      .mem_addr(mem_addr), .mem_wen(mem_wen), .mem_wdata(mem_wdata),
      .mem_wmask(mem_wmask), .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata),
      .reg_wen(reg_wen), .reg_waddr(reg_waddr), .reg_wdata(reg_wdata),
      .misalign(misalign), .busy(busy), .dbg_state(dbg_state)
   );

   // clock / reset
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   function automatic bit m_illegal(input logic [3:0] op);
      return op[3] ? op[2] : (op[2:0] == 3'b111);
   endfunction

   function automatic int m_size(input logic [3:0] op);
      return 1 << op[1:0];
   endfunction

   function automatic bit m_misal(input logic [3:0] op, input logic [63:0] addr);
      return (addr % 64'(m_size(op))) != 64'd0;
   endfunction

   function automatic logic [63:0] m_load(input logic [2:0] f3, input logic [63:0] addr,
                                          input logic [63:0] rdata);
      int n;
      int off;
      logic [63:0] v;
      logic [63:0] mask;
      n    = 1 << f3[1:0];
      off  = int'(addr % 64'd8);
      v    = rdata >> (8 * off);
      mask = (n == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 * n)) - 64'd1);
      v    = v & mask;
      if (!f3[2] && v[8*n-1]) v = v | ~mask;
      return v;
   endfunction

   function automatic logic [7:0] m_wmask(input logic [3:0] op, input logic [63:0] addr);
      int off;
      logic [15:0] m;
      off = int'(addr % 64'd8);
      m   = 16'((1 << m_size(op)) - 1) << off;
      return m[7:0];
   endfunction

   function automatic logic [63:0] m_wdata(input logic [63:0] addr, input logic [63:0] wdata);
      int off;
      off = int'(addr % 64'd8);
      return wdata << (8 * off);
   endfunction

   // ---------------- expected outputs for the current cycle ----------------
   bit          chk_en = 1'b0;
   logic        e_req_ready, e_busy, e_mvalid, e_mwen, e_misalign, e_reg_wen;
   logic [7:0]  e_wmask;
   logic [63:0] e_wdata, e_maddr;
   bit          e_wdata_chk, e_addr_chk;
   logic [W-1:0] exp_q[$];

   task automatic set_idle_exp();
      e_req_ready = 1'b1; e_busy = 1'b0; e_mvalid = 1'b0; e_mwen = 1'b0;
      e_wmask = 8'h00; e_wdata = '0; e_wdata_chk = 1'b1; e_addr_chk = 1'b0;
      e_maddr = '0; e_misalign = 1'b0; e_reg_wen = 1'b0;
   endtask

   task automatic set_req_exp(input logic [3:0] op, input logic [63:0] addr, input logic [63:0] wd);
      e_req_ready = 1'b0; e_busy = 1'b1; e_mvalid = 1'b1; e_mwen = op[3];
      e_wmask = op[3] ? m_wmask(op, addr) : 8'h00;
      e_wdata = m_wdata(addr, wd); e_wdata_chk = op[3];
      e_addr_chk = 1'b1; e_maddr = addr & ~64'h7;
      e_misalign = 1'b0; e_reg_wen = 1'b0;
   endtask

   task automatic set_wait_exp();
      e_req_ready = 1'b0; e_busy = 1'b1; e_mvalid = 1'b0; e_mwen = 1'b0;
      e_wmask = 8'h00; e_wdata = '0; e_wdata_chk = 1'b1; e_addr_chk = 1'b0;
      e_misalign = 1'b0; e_reg_wen = 1'b0;
   endtask

   // scoreboard: every cycle, away from the rising edge
   always @(negedge clk) begin
      logic [W-1:0] w;
      if (chk_en) begin
         check("req_ready", 64'(req_ready), 64'(e_req_ready));
         check("busy", 64'(busy), 64'(e_busy));
         check("mem_req_valid", 64'(mem_req_valid), 64'(e_mvalid));
         check("mem_wen", 64'(mem_wen), 64'(e_mwen));
         check("mem_wmask", 64'(mem_wmask), 64'(e_wmask));
         check("misalign", 64'(misalign), 64'(e_misalign));
         check("reg_wen", 64'(reg_wen), 64'(e_reg_wen));
         if (e_wdata_chk) check("mem_wdata", mem_wdata, e_wdata);
         if (e_addr_chk) check("mem_addr", mem_addr, e_maddr);
         if (reg_wen === 1'b1) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_errors++;
               $display("FAIL reg_write: unexpected write rd %0d data %h, none expected",
                        reg_waddr, reg_wdata);
            end else begin
               w = exp_q.pop_front();
               check("reg_waddr", 64'(reg_waddr), 64'(w[W-1:XLEN]));
               check("reg_wdata", reg_wdata, w[XLEN-1:0]);
            end
         end
      end
   end

   // ---------------- driver ----------------
   int          cap_wen_cyc, cap_mis_cyc, cap_mv_cyc, cap_rdy_cyc;
   logic [63:0] cap_reg_wdata, cap_maddr, cap_mwdata;
   logic [4:0]  cap_reg_waddr;
   logic [7:0]  cap_wmask;
   logic        cap_mwen;

   task automatic clear_caps();
      cap_wen_cyc = -1; cap_mis_cyc = -1; cap_mv_cyc = -1; cap_rdy_cyc = -1;
      cap_reg_wdata = '0; cap_maddr = '0; cap_mwdata = '0; cap_reg_waddr = '0;
      cap_wmask = '0; cap_mwen = 1'b0;
   endtask

   // One cycle: sample at the falling edge, then move just past the rising edge.
   task automatic step(input int c);
      @(negedge clk);
      if (reg_wen === 1'b1 && cap_wen_cyc < 0) begin
         cap_wen_cyc = c; cap_reg_wdata = reg_wdata; cap_reg_waddr = reg_waddr;
      end
      if (misalign === 1'b1 && cap_mis_cyc < 0) cap_mis_cyc = c;
      if (mem_req_valid === 1'b1 && cap_mv_cyc < 0) begin
         cap_mv_cyc = c; cap_maddr = mem_addr; cap_mwdata = mem_wdata;
         cap_wmask = mem_wmask; cap_mwen = mem_wen;
      end
      if (c > 0 && req_ready === 1'b1 && cap_rdy_cyc < 0) cap_rdy_cyc = c;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [63:0] rnd64();
      return {$urandom, $urandom};
   endfunction

   task automatic run_op(input logic [3:0] op, input logic [63:0] addr, input logic [63:0] wd,
                         input logic [4:0] rd, input logic [63:0] rdata,
                         input int rdy_dly, input int rsp_dly);
      int c;
      clear_caps();
      set_idle_exp();
      req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wd; req_rd = rd;
      mem_req_ready = 1'($urandom_range(0, 1));
      mem_rsp_valid = 1'($urandom_range(0, 1));
      mem_rdata = rnd64();
      step(0);
      req_valid = 1'b0; req_op = 4'($urandom); req_addr = rnd64(); req_wdata = rnd64();
      if (m_illegal(op) || m_misal(op, addr)) begin
         set_idle_exp();
         e_misalign = !m_illegal(op);
         mem_rsp_valid = 1'($urandom_range(0, 1));
         step(1);
      end else begin
         c = 1;
         for (int i = 0; i <= rdy_dly; i++) begin
            set_req_exp(op, addr, wd);
            mem_req_ready = (i == rdy_dly);
            mem_rsp_valid = 1'($urandom_range(0, 1));
            mem_rdata = rnd64();
            step(c);
            c++;
         end
         for (int i = 0; i <= rsp_dly; i++) begin
            set_wait_exp();
            mem_req_ready = 1'($urandom_range(0, 1));
            mem_rsp_valid = (i == rsp_dly);
            mem_rdata = (i == rsp_dly) ? rdata : rnd64();
            step(c);
            c++;
         end
         if (!op[3]) begin
            set_wait_exp();
            e_reg_wen = (rd != 5'd0);
            if (rd != 5'd0) exp_q.push_back({rd, m_load(op[2:0], addr, rdata)});
            mem_rsp_valid = 1'($urandom_range(0, 1));
            mem_rdata = rnd64();
            step(c);
            c++;
         end
         set_idle_exp();
         mem_rsp_valid = 1'($urandom_range(0, 1));
         step(c);
      end
      mem_rsp_valid = 1'b0;
      mem_req_ready = 1'b0;
   endtask

   task automatic reset_mid_op();
      clear_caps();
      set_idle_exp();
      req_valid = 1'b1; req_op = 4'b0011; req_addr = 64'h100; req_wdata = '0; req_rd = 5'd3;
      mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
      step(0);
      req_valid = 1'b0;
      set_req_exp(4'b0011, 64'h100, 64'h0);
      mem_req_ready = 1'b1;
      step(1);
      set_wait_exp();
      mem_req_ready = 1'b0;
      rst = 1'b1;
      step(2);
      rst = 1'b0;
      set_idle_exp();
      @(negedge clk);
      check("rst_mem_addr", mem_addr, 64'h0);
      check("rst_reg_waddr", 64'(reg_waddr), 64'h0);
      check("rst_reg_wdata", reg_wdata, 64'h0);
      @(posedge clk);
      #1;
      mem_rsp_valid = 1'b1;
      mem_rdata = 64'h1122_3344_5566_7788;
      step(4);
      step(5);
      mem_rsp_valid = 1'b0;
      step(6);
      check("rst_no_reg_wen", 64'(cap_wen_cyc), 64'(-1));
   endtask

   // ---------------- test sequence ----------------
   initial begin
      logic [3:0]  op;
      logic [63:0] a;
      rst = 1'b1; req_valid = 1'b0; req_op = '0; req_addr = '0; req_wdata = '0; req_rd = '0;
      mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rdata = '0;
      @(posedge clk);
      #1;
      set_idle_exp();
      chk_en = 1'b1;
      @(negedge clk);
      check("reset_mem_addr", mem_addr, 64'h0);
      check("reset_reg_waddr", 64'(reg_waddr), 64'h0);
      check("reset_reg_wdata", reg_wdata, 64'h0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // LW sign-extend
      run_op(4'b0010, 64'h8000_0004, 64'h0, 5'd10, 64'h8765_4321_0000_0000, 0, 0);
      check("lw_wen_cycle", 64'(cap_wen_cyc), 64'd3);
      check("lw_waddr", 64'(cap_reg_waddr), 64'd10);
      check("lw_wdata", cap_reg_wdata, 64'hFFFF_FFFF_8765_4321);
      check("lw_mem_addr", cap_maddr, 64'h8000_0000);
      check("lw_wmask", 64'(cap_wmask), 64'h0);
      check("lw_req_cycle", 64'(cap_mv_cyc), 64'd1);
      check("lw_ready_cycle", 64'(cap_rdy_cyc), 64'd4);

      // byte loads
      run_op(4'b0000, 64'h8000_0007, 64'h0, 5'd5, 64'hAB00_0000_0000_0000, 0, 0);
      check("lb_wdata", cap_reg_wdata, 64'hFFFF_FFFF_FFFF_FFAB);
      run_op(4'b0100, 64'h8000_0007, 64'h0, 5'd6, 64'hAB00_0000_0000_0000, 0, 1);
      check("lbu_wdata", cap_reg_wdata, 64'h0000_0000_0000_00AB);

      // SH lane placement
      run_op(4'b1001, 64'h8000_0002, 64'h1234, 5'd7, 64'h0, 0, 0);
      check("sh_wen", 64'(cap_mwen), 64'd1);
      check("sh_wmask", 64'(cap_wmask), 64'h0C);
      check("sh_wdata", cap_mwdata, 64'h0000_0000_1234_0000);
      check("sh_no_reg_wen", 64'(cap_wen_cyc), 64'(-1));
      check("sh_ready_cycle", 64'(cap_rdy_cyc), 64'd3);

      // misaligned LD
      run_op(4'b0011, 64'h8000_0004, 64'h0, 5'd8, 64'h0, 0, 0);
      check("mis_cycle", 64'(cap_mis_cyc), 64'd1);
      check("mis_no_req", 64'(cap_mv_cyc), 64'(-1));
      check("mis_ready", 64'(cap_rdy_cyc), 64'd1);

      // illegal encodings
      run_op(4'b0111, 64'h8000_0001, 64'h0, 5'd9, 64'h0, 0, 0);
      check("ill_ld_no_mis", 64'(cap_mis_cyc), 64'(-1));
      check("ill_ld_no_req", 64'(cap_mv_cyc), 64'(-1));
      run_op(4'b1101, 64'h8000_0003, 64'h55, 5'd9, 64'h0, 0, 0);
      check("ill_st_no_req", 64'(cap_mv_cyc), 64'(-1));

      // backpressure: 3 cycles not ready, response 5 cycles late
      run_op(4'b0011, 64'h8000_0010, 64'h0, 5'd12, 64'h0123_4567_89AB_CDEF, 3, 5);
      check("bp_wen_cycle", 64'(cap_wen_cyc), 64'd11);
      check("bp_wdata", cap_reg_wdata, 64'h0123_4567_89AB_CDEF);
      check("bp_ready_cycle", 64'(cap_rdy_cyc), 64'd12);

      // LD to x0
      run_op(4'b0011, 64'h8000_0018, 64'h0, 5'd0, 64'hDEAD_BEEF_0000_0001, 0, 2);
      check("rd0_access", 64'(cap_mv_cyc), 64'd1);
      check("rd0_no_wen", 64'(cap_wen_cyc), 64'(-1));

      reset_mid_op();

      // randomized operations
      for (int k = 0; k < 300; k++) begin
         op = 4'($urandom);
         a  = rnd64();
         if ($urandom_range(0, 3) != 0) a = a & ~64'(m_size(op) - 1);
         run_op(op, a, rnd64(), 5'($urandom), rnd64(),
                $urandom_range(0, 3), $urandom_range(0, 3));
      end

      check("exp_q_empty", 64'(exp_q.size()), 64'd0);
      chk_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
